md_scheduler: RTL and testbench
===============================

// Module: md_scheduler
// PURPOSE
//  Sequencer for the E-stage multiply/divide resource: accepts MULT/MULTU/DIV/DIVU
//  launches, models fixed multi-cycle latency, owns HI/LO and handles MTHI/MTLO.
//  Raises a stall request to the hazard logic when a D-stage HI/LO instruction
//  would collide with an in-flight operation. Sits beside the ALU in E; AO_E mux reads hi/lo.
// PARAMETERS
//  MULT_LAT  5   cycles busy after a MULT/MULTU launch (>=1)
//  DIV_LAT   10  cycles busy after a DIV/DIVU launch (>=1)
// PORTS
//  clk       in   1   system clock, all state on posedge
//  reset     in   1   synchronous, active-high; clears all state
//  start     in   1   E-stage instr is MULT/MULTU/DIV/DIVU (one-cycle pulse)
//  md_op     in   2   0 MULT, 1 MULTU, 2 DIV, 3 DIVU; valid with start
//  src_a     in   32  forwarded rs value (E stage)
//  src_b     in   32  forwarded rt value (E stage)
//  we_hi     in   1   MTHI in E: hi <= src_a
//  we_lo     in   1   MTLO in E: lo <= src_a
//  d_is_md   in   1   D-stage instr is MULT*/DIV*/MFHI/MFLO/MTHI/MTLO
//  busy      out  1   operation in flight
//  hi        out  32  HI register
//  lo        out  32  LO register
//  stall_md  out  1   request to freeze F/D and bubble E
// BEHAVIOUR
//  - Reset: state IDLE, cnt=0, busy=0, hi=lo=0, pend_hi=pend_lo=0; aborts any op in flight.
//  - States: IDLE, BUSY. busy = (state==BUSY), registered-state decode.
//  - IDLE & start at edge t: pend_hi/pend_lo <= result, cnt <= LAT(op), ->BUSY.
//    Result: MULT {hi,lo}=$signed(a)*$signed(b) 64b; MULTU unsigned 64b;
//    DIV lo=quot, hi=rem signed (rem takes sign of dividend); DIVU unsigned.
//  - BUSY: cnt decrements each edge; at edge where cnt==1: hi<=pend_hi, lo<=pend_lo,
//    ->IDLE. So busy=1 for exactly LAT cycles after the launch edge; new hi/lo
//    visible in first cycle busy=0. hi/lo hold old values while busy.
//  - Divide by zero: op still takes DIV_LAT cycles; hi/lo unchanged at commit.
//  - start while BUSY: ignored (illegal; stall_md prevents it; bench asserts never).
//  - we_hi/we_lo in IDLE: write src_a same edge; start and we_* same cycle -> we_* wins,
//    start ignored (illegal combo, asserted). we_* while BUSY: ignored.
//  - stall_md = d_is_md & (busy | start), combinational; stalls until cycle busy=0.
//  - Arithmetic: 64b products, no overflow; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  - cnt width = $clog2(max(MULT_LAT,DIV_LAT))+1; no wrap possible.
// STRUCTURE
//  - md_pkg: MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op codes, ST_IDLE/ST_BUSY encodings.
//  - Sub-module md_arith: combinational 64b result from (md_op,a,b), div-by-zero flag.
//  - Top: FSM, counter, pend/HI/LO regs, stall logic.
// TESTING
//  1 MULT a=-3,b=7 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFEB.
//  2 DIVU a=100,b=7 -> busy 10 cycles, then lo=14 hi=2; DIV a=-7,b=2 -> lo=-3 hi=-1.
//  3 d_is_md held during MULT launch -> stall_md=1 on launch cycle and all 5 busy cycles, 0 after.
//  4 DIV b=0 with hi=0x11,lo=0x22 -> busy 10 cycles, hi/lo still 0x11/0x22.
//  5 MTHI src_a=0xDEAD in IDLE -> hi=0xDEAD next cycle; MTLO during BUSY -> lo unchanged.
//  6 reset asserted at cycle 3 of DIV -> busy=0, hi=lo=0 next cycle, no late commit.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM states and helpers shared by the multiply/divide scheduler
package md_pkg;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  function automatic logic is_div(md_op_t op);
    return op[1];
  endfunction
endpackage

// File: rtl/md_scheduler_if.sv
// md_scheduler_if: E-stage launch, MTHI/MTLO and stall signals of the mul/div resource
interface md_scheduler_if;
  logic start;
  md_pkg::md_op_t md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic we_hi;
  logic we_lo;
  logic d_is_md;
  logic busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic stall_md;
  modport master (output start, md_op, src_a, src_b, we_hi, we_lo, d_is_md, input busy, hi, lo, stall_md);
  modport slave (input start, md_op, src_a, src_b, we_hi, we_lo, d_is_md, output busy, hi, lo, stall_md);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational {hi,lo} result of MULT/MULTU/DIV/DIVU plus divide-by-zero flag
module md_arith import md_pkg::*; (
  input  md_op_t      md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        dz
);
  logic [63:0] sprod, uprod;
  logic [31:0] da, db, q, r, sq, sr;
  logic sgn;
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};
  assign sgn = md_op == MD_DIV;
  // Signed divide runs on magnitudes so 0x80000000 / -1 stays well defined
  assign da = (sgn & a[31]) ? -a : a;
  assign db = (sgn & b[31]) ? -b : b;
  assign dz = b == 32'd0;
  assign q = dz ? 32'd0 : da / db;
  assign r = dz ? 32'd0 : da % db;
  assign sq = (sgn & (a[31] ^ b[31])) ? -q : q;
  assign sr = (sgn & a[31]) ? -r : r;
  assign res = is_div(md_op) ? {sr, sq} : (md_op == MD_MULT) ? sprod : uprod;
endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: fixed-latency mul/div sequencer owning HI/LO with hazard stall request
module md_scheduler import md_pkg::*; #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic clk,
  input logic reset,
  md_scheduler_if.slave bus
);
  localparam int CW = $clog2(MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic [63:0] res;
  logic dz;
  md_arith u_arith (.md_op(bus.md_op), .a(bus.src_a), .b(bus.src_b), .res(res), .dz(dz));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.we_hi | bus.we_lo) begin
        if (bus.we_hi) hi <= bus.src_a;
        if (bus.we_lo) lo <= bus.src_a;
      end else if (bus.start) begin
        {pend_hi, pend_lo} <= (is_div(bus.md_op) & dz) ? {hi, lo} : res;
        cnt <= is_div(bus.md_op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
        state <= ST_BUSY;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
        state <= ST_IDLE;
      end
    end
  end
  assign bus.busy = state == ST_BUSY;
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.stall_md = bus.d_is_md & (bus.busy | bus.start);
endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed and random launches checked against a transaction-level HI/LO model
module tb_md_scheduler;
  import md_pkg::*;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT = 10;
  logic clk = 0, reset = 1;
  int checks = 0, failures = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  md_scheduler_if bus ();
  md_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint q, r;
    if (op == MD_MULT) return 64'(sa * sb);
    if (op == MD_MULTU) return 64'(ua * ub);
    if (b == 0) return {m_hi, m_lo};
    if (op == MD_DIVU) return {32'(ua % ub), 32'(ua / ub)};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic launch(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input bit dmd, input bit poke);
    int lat = is_div(op) ? DIV_LAT : MULT_LAT;
    logic [63:0] exp = ref_res(op, a, b);
    bus.start = 1; bus.md_op = op; bus.src_a = a; bus.src_b = b; bus.d_is_md = dmd;
    #1 chk("stall_launch", bus.stall_md, dmd);
    chk("idle_before", bus.busy, 0);
    @(negedge clk);
    bus.start = 0; bus.we_lo = poke; bus.src_a = ~m_lo;
    for (int i = 0; i < lat; i++) begin
      #1 chk("busy", bus.busy, 1);
      chk("hi_hold", bus.hi, m_hi);
      chk("lo_hold", bus.lo, m_lo);
      chk("stall_busy", bus.stall_md, dmd);
      @(negedge clk);
    end
    bus.we_lo = 0;
    #1 chk("busy_done", bus.busy, 0);
    chk("stall_done", bus.stall_md, 0);
    {m_hi, m_lo} = exp;
    chk("hi_commit", bus.hi, m_hi);
    chk("lo_commit", bus.lo, m_lo);
    bus.d_is_md = 0;
  endtask

  task automatic mt(input bit wh, input bit wl, input logic [31:0] v);
    bus.we_hi = wh; bus.we_lo = wl; bus.src_a = v;
    @(negedge clk);
    bus.we_hi = 0; bus.we_lo = 0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    #1 chk("mt_hi", bus.hi, m_hi);
    chk("mt_lo", bus.lo, m_lo);
    chk("mt_busy", bus.busy, 0);
  endtask

  initial begin
    bus.start = 0; bus.md_op = MD_MULT; bus.src_a = 0; bus.src_b = 0;
    bus.we_hi = 0; bus.we_lo = 0; bus.d_is_md = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_stall", bus.stall_md, 0);
    launch(MD_MULT, -32'sd3, 32'd7, 1, 0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
    launch(MD_DIVU, 32'd100, 32'd7, 0, 0);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);
    launch(MD_DIV, -32'sd7, 32'd2, 0, 0);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    mt(1, 1, 32'h0);
    mt(1, 0, 32'h11);
    mt(0, 1, 32'h22);
    launch(MD_DIV, 32'd55, 32'd0, 1, 0);
    chk("dz_hi", bus.hi, 32'h11);
    chk("dz_lo", bus.lo, 32'h22);
    mt(1, 0, 32'hDEAD);
    chk("mthi", bus.hi, 32'hDEAD);
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'h0);
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 20));
      launch(md_op_t'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    mt(1, 1, 32'h1234_5678);
    bus.start = 1; bus.md_op = MD_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_hi = 0; m_lo = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    repeat (DIV_LAT + 2) @(negedge clk);
    chk("late_busy", bus.busy, 0);
    chk("late_hi", bus.hi, 0);
    chk("late_lo", bus.lo, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
